avalon_slave_uart: RTL
======================

AVALON_SLAVE_UART -- requirements
Module: avalon_slave_uart

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, reset baud rate; DIV_RST = CLK_HZ/BAUD (434), truncated.
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port address  input  2  Avalon-MM word address.
REQ-006 SHALL have ports read, write  input  1 each  Avalon-MM read and write strobes.
REQ-007 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-008 SHALL have port readdata  output  32  Avalon-MM read data, registered.
REQ-009 SHALL have port readdatavalid  output  1  high for one cycle when readdata is valid.
REQ-010 SHALL have port waitrequest  output  1  stalls a write to TXDATA while the transmitter is busy.
REQ-011 SHALL have port rx  input  1  RS232 serial input, asynchronous to CLK.
REQ-012 SHALL have port tx  output  1  RS232 serial output, idle high.

Function
REQ-013 Register map: 0 TXDATA (write only, [7:0]); 1 RXDATA (read only, [7:0]); 2 STATUS; 3 DIVISOR ([15:0], read/write).
REQ-014 STATUS bits: [0] tx_busy, [1] rx_valid, [2] rx_overrun, [3] frame_err; other bits read 0.
REQ-015 Read latency SHALL be fixed at 1 cycle: readdatavalid and readdata are asserted in the cycle after read is sampled; reads are never stalled.
REQ-016 A read of TXDATA SHALL return 0; writes to RXDATA SHALL be ignored.
REQ-017 A read of RXDATA SHALL clear rx_valid in the same edge as the read is sampled.
REQ-018 Writing STATUS with bit2 or bit3 = 1 SHALL clear the corresponding flag; all other bits are ignored.
REQ-019 Writing 0 or 1 to DIVISOR SHALL store 2; the new value applies from the next bit period.
REQ-020 A write to TXDATA while tx_busy=1 SHALL hold waitrequest high until the cycle in which the TX FSM returns to IDLE; the write is accepted in that cycle.
REQ-021 A write to TXDATA while tx_busy=0 SHALL be accepted with waitrequest low, set tx_busy the next cycle, and start the frame.
REQ-022 TX FSM states: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE; each state lasts DIVISOR cycles; tx = 1 in IDLE and STOP, 0 in START.
REQ-023 rx SHALL pass through a 2-flop synchronizer before use.
REQ-024 RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE; a falling edge of the synchronized rx leaves IDLE.
REQ-025 In START, rx is resampled at DIVISOR/2; if it is high, the FSM returns to IDLE (glitch) and no flag changes.
REQ-026 Data bits SHALL be sampled DIVISOR cycles apart, starting DIVISOR cycles after the start-bit midpoint.
REQ-027 At the STOP sample, the byte SHALL be loaded into RXDATA and rx_valid set; if the stop bit is 0, frame_err is set and the byte is still loaded.
REQ-028 If rx_valid=1 when a new byte completes, rx_overrun SHALL be set and RXDATA overwritten.
REQ-029 If an RXDATA read coincides with a byte completing, the new byte wins: rx_valid stays 1 and rx_overrun is not set.

Reset
REQ-030 While RST=0, all outputs and state SHALL be held at reset values: tx=1, readdata=0, readdatavalid=0, waitrequest=0, flags=0, DIVISOR=DIV_RST, both FSMs in IDLE, synchronizer flops=1.
REQ-031 Assertion of RST mid-frame SHALL abort the frame immediately; no partial byte is retained.

Structure
REQ-032 A shared package SHALL hold the register address constants, the STATUS bit indices, and the TX/RX state enum types.
REQ-033 The RX path SHALL be one sub-module, uart_rx_core (synchronizer plus RX FSM); the TX FSM and register file stay in the top.

Verification
REQ-034 DIVISOR=4, write 0xA5 to TXDATA -> tx shows 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop), 4 cycles per bit; tx_busy=1 for 40 cycles.
REQ-035 Write 0x11 to TXDATA, then write 0x22 immediately -> waitrequest stays high until the first frame reaches IDLE; 0x22 follows with no idle gap longer than 1 cycle.
REQ-036 Drive 0x3C on rx at DIVISOR=8 -> rx_valid=1; read RXDATA -> readdatavalid one cycle later with readdata=0x0000003C, and rx_valid=0 afterwards.
REQ-037 Send two bytes without reading -> rx_overrun=1 and RXDATA holds the second byte; write STATUS 0x4 -> rx_overrun=0.
REQ-038 Send a frame with stop bit 0 -> frame_err=1; a 2-cycle low glitch on rx at DIVISOR=8 -> no flag change.
REQ-039 Pull RST low mid-TX frame -> tx=1 and tx_busy=0 asynchronously; DIVISOR reads back 434 after release.

Source files
------------

// File: rtl/avalon_slave_uart_pkg.sv
// Shared definitions for the Avalon-MM UART: register map, STATUS bit
// positions and the TX/RX state encodings.
package avalon_slave_uart_pkg;

    localparam logic [1:0] ADDR_TXDATA  = 2'd0;
    localparam logic [1:0] ADDR_RXDATA  = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_DIVISOR = 2'd3;

    localparam int STAT_TX_BUSY    = 0;
    localparam int STAT_RX_VALID   = 1;
    localparam int STAT_RX_OVERRUN = 2;
    localparam int STAT_FRAME_ERR  = 3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // A bit period shorter than 2 cycles leaves no room for the RX midpoint sample.
    function automatic logic [15:0] clamp_divisor(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

endpackage

// File: rtl/avalon_slave_uart_rx_core.sv
// RX path: two-flop synchronizer, falling-edge start detect and the RX FSM.
// Presents a one-cycle done strobe with the byte and stop-bit status.
module uart_rx_core
    import avalon_slave_uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [15:0] divisor,
    output logic        done,
    output logic [7:0]  data,
    output logic        frame_bad
);

    logic [1:0]  sync;
    logic        rx_s;
    logic        rx_prev;
    logic        fall;
    rx_state_t   state, state_nxt;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        cnt_zero;

    assign rx_s     = sync[1];
    assign fall     = rx_prev & ~rx_s;
    assign cnt_zero = (cnt == 16'd0);
    assign data     = shreg;

    // Synchronizer resets to the idle line level so reset release is not seen as a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], rx};
            rx_prev <= sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (fall) state_nxt = RX_START;
            RX_START: if (cnt_zero) state_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_zero && bit_idx == 3'd7) state_nxt = RX_STOP;
            RX_STOP:  if (cnt_zero) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    // Bit timer and shift register; each reload picks up the current divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (state == RX_IDLE) begin
            if (fall) begin
                cnt     <= (divisor >> 1) - 16'd1;
                bit_idx <= '0;
            end
        end else if (cnt_zero) begin
            cnt <= divisor - 16'd1;
            if (state == RX_DATA) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

    always_comb begin
        done      = (state == RX_STOP) && cnt_zero;
        frame_bad = done && !rx_s;
    end

endmodule

// File: rtl/avalon_slave_uart.sv
// Avalon-MM slave UART: register file, TX FSM and the RX core instance.
// Reads have a fixed one-cycle latency; only TXDATA writes can be stalled.
module avalon_slave_uart
    import avalon_slave_uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        waitrequest,
    input  logic        rx,
    output logic        tx
);

    localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD);

    logic [15:0] divisor;
    tx_state_t   tx_state, tx_state_nxt;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shreg;
    logic        tx_cnt_zero, tx_busy, wr_tx, tx_accept;
    logic        rx_valid, rx_overrun, frame_err;
    logic [7:0]  rxdata;
    logic        rx_done, rx_frame_bad, rd_rx, wr_status;
    logic [7:0]  rx_byte;
    logic [31:0] status, rd_mux;
    logic        unused_wdata;

    assign unused_wdata = ^writedata[31:16];

    assign tx_cnt_zero = (tx_cnt == 16'd0);
    assign tx_busy     = (tx_state != TX_IDLE);
    assign wr_tx       = write && (address == ADDR_TXDATA);
    assign tx_accept   = wr_tx && !tx_busy;
    assign rd_rx       = read && (address == ADDR_RXDATA);
    assign wr_status   = write && (address == ADDR_STATUS);

    uart_rx_core u_rx (
        .clk       (CLK),
        .rst_n     (RST),
        .rx        (rx),
        .divisor   (divisor),
        .done      (rx_done),
        .data      (rx_byte),
        .frame_bad (rx_frame_bad)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) tx_state <= TX_IDLE;
        else      tx_state <= tx_state_nxt;
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_accept) tx_state_nxt = TX_START;
            TX_START: if (tx_cnt_zero) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_cnt_zero && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
            TX_STOP:  if (tx_cnt_zero) tx_state_nxt = TX_IDLE;
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (tx_state)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = tx_shreg[0];
            default:  tx = 1'b1;
        endcase
        // The stalled write completes in the first IDLE cycle after STOP.
        waitrequest = wr_tx && tx_busy;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
        end else if (tx_accept) begin
            tx_shreg <= writedata[7:0];
            tx_cnt   <= divisor - 16'd1;
            tx_bit   <= '0;
        end else if (tx_busy) begin
            if (tx_cnt_zero) begin
                tx_cnt <= divisor - 16'd1;
                if (tx_state == TX_DATA) begin
                    tx_shreg <= {1'b0, tx_shreg[7:1]};
                    tx_bit   <= tx_bit + 3'd1;
                end
            end else begin
                tx_cnt <= tx_cnt - 16'd1;
            end
        end
    end

    always_comb begin
        status                  = '0;
        status[STAT_TX_BUSY]    = tx_busy;
        status[STAT_RX_VALID]   = rx_valid;
        status[STAT_RX_OVERRUN] = rx_overrun;
        status[STAT_FRAME_ERR]  = frame_err;
        rd_mux = '0;
        case (address)
            ADDR_RXDATA:  rd_mux = {24'd0, rxdata};
            ADDR_STATUS:  rd_mux = status;
            ADDR_DIVISOR: rd_mux = {16'd0, divisor};
            default:      rd_mux = '0;
        endcase
    end

    // A byte completing in the same cycle as an RXDATA read wins over the read.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            divisor       <= DIV_RST;
            rxdata        <= '0;
            rx_valid      <= 1'b0;
            rx_overrun    <= 1'b0;
            frame_err     <= 1'b0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            if (write && address == ADDR_DIVISOR)
                divisor <= clamp_divisor(writedata[15:0]);

            if (rx_done)    rxdata <= rx_byte;

            if (rx_done)    rx_valid <= 1'b1;
            else if (rd_rx) rx_valid <= 1'b0;

            if (rx_done && rx_valid && !rd_rx)
                rx_overrun <= 1'b1;
            else if (wr_status && writedata[STAT_RX_OVERRUN])
                rx_overrun <= 1'b0;

            if (rx_done && rx_frame_bad)
                frame_err <= 1'b1;
            else if (wr_status && writedata[STAT_FRAME_ERR])
                frame_err <= 1'b0;

            readdatavalid <= read;
            if (read) readdata <= rd_mux;
        end
    end

endmodule
